df_edge_sched: RTL and testbench

DF_EDGE_SCHED -- requirements
Module: DF_edge_sched

---
 rtl/df_edge_sched_if.sv | 28 ++
 rtl/df_edge_sched.sv | 142 ++++++++++++++
 tb/tb_df_edge_sched.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/df_edge_sched_if.sv
// Handshake/status bundle for the deblocking-filter edge scheduler.
// The master drives MB start parameters and stall; the slave (scheduler) drives status.
interface df_edge_sched_if;
   logic       start;
   logic       disable_DF;
   logic [3:0] mb_num_h;
   logic [3:0] mb_num_v;
   logic       stall;
   logic       busy;
   logic       edge_valid;
   logic [5:0] DF_edge_counter;
   logic [1:0] one_edge_counter;
   logic       mbAddrA_rd;
   logic       mbAddrB_rd;
   logic       end_of_MB_DF;

   modport master (
      output start, disable_DF, mb_num_h, mb_num_v, stall,
      input  busy, edge_valid, DF_edge_counter, one_edge_counter,
             mbAddrA_rd, mbAddrB_rd, end_of_MB_DF
   );

   modport slave (
      input  start, disable_DF, mb_num_h, mb_num_v, stall,
      output busy, edge_valid, DF_edge_counter, one_edge_counter,
             mbAddrA_rd, mbAddrB_rd, end_of_MB_DF
   );
endinterface

// File: rtl/df_edge_sched.sv
// Deblocking-filter edge scheduler: walks the 48 luma/chroma edges of one MB,
// four pixel lines per edge, skipping picture-boundary edges in a single cycle.
module df_edge_sched (
   input  logic            clk,
   input  logic            reset,
   df_edge_sched_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e     state_q, state_d;
   logic [5:0] edge_q, edge_d;
   logic [1:0] line_q, line_d;
   logic       valid_q, valid_d;
   logic       rda_q, rda_d;
   logic       rdb_q, rdb_d;
   logic       busy_q, busy_d;
   logic       eom_q, eom_d;
   logic       hz_q, hz_d;
   logic       vz_q, vz_d;

   logic       load;
   logic [5:0] nxt_edge;
   logic       nxt_left, nxt_top, nxt_skip;

   function automatic logic is_left(input logic [5:0] e);
      if (e < 6'd16) return (e[1:0] == 2'b00);
      if (e >= 6'd32 && e < 6'd40) return !e[1];
      return 1'b0;
   endfunction

   function automatic logic is_top(input logic [5:0] e);
      if (e >= 6'd16 && e < 6'd20) return 1'b1;
      if (e >= 6'd40) return !e[1];
      return 1'b0;
   endfunction

   always_comb begin
      state_d  = state_q;
      edge_d   = edge_q;
      line_d   = line_q;
      valid_d  = valid_q;
      rda_d    = rda_q;
      rdb_d    = rdb_q;
      busy_d   = busy_q;
      eom_d    = 1'b0;
      hz_d     = hz_q;
      vz_d     = vz_q;
      load     = 1'b0;
      nxt_edge = '0;
      nxt_left = 1'b0;
      nxt_top  = 1'b0;
      nxt_skip = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               hz_d = (bus.mb_num_h == 4'd0);
               vz_d = (bus.mb_num_v == 4'd0);
               if (bus.disable_DF) begin
                  state_d = DONE;
                  eom_d   = 1'b1;
               end else begin
                  state_d = RUN;
                  busy_d  = 1'b1;
                  load    = 1'b1;
               end
            end
         end
         RUN: begin
            // A skipped edge (valid low) lasts one cycle; a filtered edge lasts four lines.
            if (!bus.stall) begin
               if (!valid_q || line_q == 2'd3) begin
                  if (edge_q == 6'd47) begin
                     state_d = DONE;
                     busy_d  = 1'b0;
                     valid_d = 1'b0;
                     rda_d   = 1'b0;
                     rdb_d   = 1'b0;
                     edge_d  = '0;
                     line_d  = '0;
                     eom_d   = 1'b1;
                  end else begin
                     nxt_edge = edge_q + 6'd1;
                     load     = 1'b1;
                  end
               end else begin
                  line_d = line_q + 2'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (load) begin
         nxt_left = is_left(nxt_edge);
         nxt_top  = is_top(nxt_edge);
         nxt_skip = (nxt_left && hz_d) || (nxt_top && vz_d);
         edge_d   = nxt_edge;
         line_d   = '0;
         valid_d  = !nxt_skip;
         rda_d    = !nxt_skip && nxt_left;
         rdb_d    = !nxt_skip && nxt_top;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         edge_q  <= '0;
         line_q  <= '0;
         valid_q <= 1'b0;
         rda_q   <= 1'b0;
         rdb_q   <= 1'b0;
         busy_q  <= 1'b0;
         eom_q   <= 1'b0;
         hz_q    <= 1'b0;
         vz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         edge_q  <= edge_d;
         line_q  <= line_d;
         valid_q <= valid_d;
         rda_q   <= rda_d;
         rdb_q   <= rdb_d;
         busy_q  <= busy_d;
         eom_q   <= eom_d;
         hz_q    <= hz_d;
         vz_q    <= vz_d;
      end
   end

   assign bus.busy             = busy_q;
   assign bus.edge_valid       = valid_q;
   assign bus.DF_edge_counter  = edge_q;
   assign bus.one_edge_counter = line_q;
   assign bus.mbAddrA_rd       = rda_q;
   assign bus.mbAddrB_rd       = rdb_q;
   assign bus.end_of_MB_DF     = eom_q;

endmodule

// File: tb/tb_df_edge_sched.sv
// Scoreboard bench for df_edge_sched: a driver pushes the expected per-cycle edge
// stream for each MB, and a monitor pops and compares every RUN/DONE cycle.
module tb_df_edge_sched;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   df_edge_sched_if dif();

   df_edge_sched dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   typedef struct {
      int e;
      int ln;
      bit v;
      bit ra;
      bit rb;
   } rec_t;

   rec_t exp_q[$];
   int   len_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input int act, input int expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic bit left_edge(input int e);
      return e inside {0, 4, 8, 12, 32, 33, 36, 37};
   endfunction

   function automatic bit top_edge(input int e);
      return e inside {[16:19], 40, 41, 44, 45};
   endfunction

   task automatic push_model(input int h, input int v, input bit dis);
      int   n = 0;
      rec_t r;
      if (!dis) begin
         for (int e = 0; e < 48; e++) begin
            if ((left_edge(e) && h == 0) || (top_edge(e) && v == 0)) begin
               r.e = e; r.ln = 0; r.v = 0; r.ra = 0; r.rb = 0;
               exp_q.push_back(r);
               n++;
            end else begin
               for (int ln = 0; ln < 4; ln++) begin
                  r.e = e; r.ln = ln; r.v = 1; r.ra = left_edge(e); r.rb = top_edge(e);
                  exp_q.push_back(r);
                  n++;
               end
            end
         end
      end
      len_q.push_back(n);
   endtask

   // Monitor: samples on the falling edge, away from register updates.
   initial begin
      int   cyc = 0, t0 = 0, stalls = 0, nrec;
      bit   in_mb = 0, prev_stall = 0, have_last = 0, ok;
      rec_t last, r;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset === 1'b1) begin
            exp_q.delete(); len_q.delete();
            in_mb = 0; prev_stall = 0; have_last = 0;
            continue;
         end
         if (!in_mb && dif.start && !dif.busy && !dif.end_of_MB_DF) begin
            in_mb = 1; t0 = cyc; stalls = 0;
         end
         if (dif.busy) begin
            ok = 1;
            if (prev_stall && have_last) begin
               r = last;
               stalls++;
            end else if (exp_q.size() == 0) begin
               chk("busy_without_expected", exp_q.size(), 1);
               ok = 0;
            end else begin
               r = exp_q.pop_front();
            end
            if (ok) begin
               chk("edge_idx",   dif.DF_edge_counter,  r.e);
               chk("line_idx",   dif.one_edge_counter, r.ln);
               chk("edge_valid", dif.edge_valid,       r.v);
               chk("mbAddrA_rd", dif.mbAddrA_rd,       r.ra);
               chk("mbAddrB_rd", dif.mbAddrB_rd,       r.rb);
               chk("eom_in_run", dif.end_of_MB_DF,     0);
               last = r; have_last = 1;
            end
            prev_stall = dif.stall;
         end else begin
            prev_stall = 0; have_last = 0;
            if (dif.end_of_MB_DF) begin
               if (in_mb && len_q.size() > 0) begin
                  nrec = len_q.pop_front();
                  chk("done_cycles",   cyc - t0, nrec + 1 + stalls);
                  chk("leftover_recs", exp_q.size(), 0);
                  chk("valid_in_done", dif.edge_valid, 0);
               end else begin
                  chk("spurious_done", dif.end_of_MB_DF, 0);
               end
               in_mb = 0;
            end
         end
      end
   end

   task automatic issue(input int h, input int v, input bit dis, input int exp_lat,
                        input int stall_e, input int stall_l, input int reset_e,
                        input int restart_k, input bit rnd_stall);
      int k = 0, rem = 0;
      bit done = 0, stalled = 0;
      repeat (2) begin @(posedge clk); #1; end
      push_model(h, v, dis);
      dif.mb_num_h   = 4'(h);
      dif.mb_num_v   = 4'(v);
      dif.disable_DF = dis;
      dif.start      = 1'b1;
      while (!done && k < 2000) begin
         @(posedge clk); #1;
         k++;
         dif.start      = (k == restart_k);
         dif.mb_num_h   = 4'($urandom);
         dif.mb_num_v   = 4'($urandom);
         dif.disable_DF = 1'($urandom);
         if (reset) begin
            chk("rst_busy",  dif.busy,             0);
            chk("rst_edge",  dif.DF_edge_counter,  0);
            chk("rst_line",  dif.one_edge_counter, 0);
            chk("rst_valid", dif.edge_valid,       0);
            chk("rst_eom",   dif.end_of_MB_DF,     0);
            chk("rst_rdA",   dif.mbAddrA_rd,       0);
            chk("rst_rdB",   dif.mbAddrB_rd,       0);
            reset = 1'b0;
            done  = 1;
         end else if (dif.end_of_MB_DF) begin
            done = 1;
            if (exp_lat >= 0) chk("start_to_done", k, exp_lat);
         end else if (reset_e >= 0 && dif.busy && dif.DF_edge_counter == 6'(reset_e)) begin
            reset = 1'b1;
         end
         if (rem > 0) begin
            rem--;
            if (rem == 0) dif.stall = 1'b0;
         end else if (!stalled && stall_e >= 0 && dif.busy &&
                      dif.DF_edge_counter == 6'(stall_e) && dif.one_edge_counter == 2'(stall_l)) begin
            dif.stall = 1'b1;
            rem = 5;
            stalled = 1;
         end else if (rnd_stall) begin
            dif.stall = ($urandom_range(0, 7) == 0);
         end else begin
            dif.stall = 1'b0;
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL mb_timeout: no end_of_MB_DF after %0d cycles", k);
      end
      dif.stall = 1'b0;
      dif.start = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      dif.start      = 1'b0;
      dif.stall      = 1'b0;
      dif.disable_DF = 1'b0;
      dif.mb_num_h   = '0;
      dif.mb_num_v   = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("init_busy",  dif.busy,             0);
      chk("init_edge",  dif.DF_edge_counter,  0);
      chk("init_line",  dif.one_edge_counter, 0);
      chk("init_valid", dif.edge_valid,       0);
      chk("init_eom",   dif.end_of_MB_DF,     0);
      chk("init_rdA",   dif.mbAddrA_rd,       0);
      chk("init_rdB",   dif.mbAddrB_rd,       0);

      issue(2, 3, 0, 193, -1, -1, -1, -1, 0);
      issue(0, 0, 0, 145, -1, -1, -1, -1, 0);
      issue(5, 7, 1, 1,   -1, -1, -1, -1, 0);
      issue(1, 5, 0, 198, 17,  2, -1, -1, 0);
      issue(4, 4, 0, -1,  -1, -1, 30, -1, 0);
      issue(9, 2, 0, 193, -1, -1, -1, -1, 0);
      issue(3, 3, 0, 193, -1, -1, -1, 10, 0);
      for (int i = 0; i < 12; i++)
         issue($urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
               -1, -1, -1, -1, -1, 1);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
